// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and decode helpers for the ALU execute controller.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam logic [3:0] IADD   = 4'b0000;
  localparam logic [3:0] ISUB   = 4'b0001;
  localparam logic [3:0] IAND   = 4'b0010;
  localparam logic [3:0] IOR    = 4'b0011;
  localparam logic [3:0] IXOR   = 4'b0100;
  localparam logic [3:0] ISLL   = 4'b1000;
  localparam logic [3:0] ISLR   = 4'b1001;
  localparam logic [3:0] ISRL   = 4'b1010;
  localparam logic [3:0] ISRA   = 4'b1011;
  localparam logic [3:0] INON   = 4'b1111;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_LI  = 4'b1100;

  localparam int FLG_S = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_ALU = 3'd0,
    K_CMP = 3'd1,
    K_LI  = 3'd2,
    K_NOP = 3'd3,
    K_ILL = 3'd4
  } op_kind_t;

  function automatic op_kind_t decode_op(input logic [3:0] op);
    case (op)
      IADD, ISUB, IAND, IOR, IXOR, ISLL, ISLR, ISRL, ISRA: return K_ALU;
      OP_CMP: return K_CMP;
      OP_LI:  return K_LI;
      INON:   return K_NOP;
      default: return K_ILL;
    endcase
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// 8x16 register file: two operand read ports, one debug read port, one write port.
module regfile_8x16
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [0:(1<<ADDR_W)-1];

  // Reset wins over a same-cycle write so an aborted write-back never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1<<ADDR_W); i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute controller: issues instructions to the external ALU and writes back
// results and flags. One instruction every three cycles: accept, execute, write back.
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] INSTR_IN,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  output logic [3:0]        S_ALU,
  output logic [DATA_W-1:0] DATA_A,
  output logic [DATA_W-1:0] DATA_B,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic [3:0]        FLAG_IN,
  output logic [3:0]        FLAG_REG,
  output logic              WB_VALID,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              ERR,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA
);

  // state   | meaning
  // --------+-----------------------------------------------------------
  // ST_IDLE | ready for an instruction; S_ALU parked at INON
  // ST_EXEC | opcode/operands on the ALU bus; result captured at end
  // ST_WB   | WB_VALID or ERR pulse; register and flag commit at end

  state_t            state_q, state_d;
  op_kind_t          kind_in, kind_q;
  logic [3:0]        op_in;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic [3:0]        flag_hold_q;
  logic              flag_upd_q;
  logic              accept, load_ops, capture, commit;
  logic              rf_we;
  logic              instr_unused;

  assign op_in        = INSTR_IN[15:12];
  assign kind_in      = decode_op(op_in);
  assign instr_unused = ^INSTR_IN[2:0];

  assign INSTR_READY = (state_q == ST_IDLE) && !RST;
  assign accept      = INSTR_VALID && INSTR_READY;
  assign rf_we       = commit && WB_VALID;

  always_comb begin
    state_d  = state_q;
    load_ops = 1'b0;
    capture  = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_EXEC;
          load_ops = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
        capture = 1'b1;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        commit  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      kind_q      <= K_NOP;
      rd_q        <= '0;
      imm_q       <= '0;
      S_ALU       <= INON;
      DATA_A      <= '0;
      DATA_B      <= '0;
      flag_hold_q <= '0;
      flag_upd_q  <= 1'b0;
      FLAG_REG    <= '0;
      WB_VALID    <= 1'b0;
      WB_ADDR     <= '0;
      WB_DATA     <= '0;
      ERR         <= 1'b0;
    end else begin
      state_q  <= state_d;
      WB_VALID <= 1'b0;
      ERR      <= 1'b0;

      if (load_ops) begin
        kind_q <= kind_in;
        rd_q   <= INSTR_IN[11:9];
        imm_q  <= {{(DATA_W-9){INSTR_IN[8]}}, INSTR_IN[8:0]};
        DATA_A <= ra_data;
        DATA_B <= rb_data;
        case (kind_in)
          K_ALU:   S_ALU <= op_in;
          K_CMP:   S_ALU <= ISUB;
          default: S_ALU <= INON;
        endcase
      end

      if (capture) begin
        S_ALU       <= INON;
        ERR         <= (kind_q == K_ILL);
        flag_upd_q  <= (kind_q == K_ALU) || (kind_q == K_CMP);
        flag_hold_q <= FLAG_IN;
        if ((kind_q == K_ALU) || (kind_q == K_LI)) begin
          WB_VALID <= 1'b1;
          WB_ADDR  <= rd_q;
          WB_DATA  <= (kind_q == K_LI) ? imm_q : ALU_OUT;
        end
      end

      if (commit && flag_upd_q) begin
        FLAG_REG <= flag_hold_q;
      end
    end
  end

  regfile_8x16 u_regfile (
    .clk      (CLK),
    .rst      (RST),
    .we       (rf_we),
    .waddr    (WB_ADDR),
    .wdata    (WB_DATA),
    .ra_addr  (INSTR_IN[8:6]),
    .rb_addr  (INSTR_IN[5:3]),
    .dbg_addr (RD_ADDR),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (RD_DATA)
  );

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Sequential execute controller that drives the 16-bit combinational ALU as its initiator. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8x16 register file. It then drives S_ALU/DATA_A/DATA_B, captures ALU_OUT and FLAG_IN, and writes back both the result and a flag register. It sits between instruction fetch and the ALU in the simple CPU datapath.

## Interface
- DATA_W, 16, datapath width; must match the ALU.
- ADDR_W, 3, register address width; 8 registers.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- INSTR_IN  in  16  instruction word.
- INSTR_VALID  in  1  instruction present.
- INSTR_READY  out  1  controller can accept.
- S_ALU  out  4  ALU opcode, registered.
- DATA_A  out  16  ALU operand A, registered.
- DATA_B  out  16  ALU operand B, registered.
- ALU_OUT  in  16  ALU result.
- FLAG_IN  in  4  ALU flags {S,Z,C,V}.
- FLAG_REG  out  4  architectural flags {S,Z,C,V}.
- WB_VALID  out  1  one-cycle pulse on register write.
- WB_ADDR  out  3  written register.
- WB_DATA  out  16  written value.
- ERR  out  1  one-cycle pulse on illegal opcode.
- RD_ADDR  in  3  debug read address.
- RD_DATA  out  16  debug read data; combinational read of the register file.

## Operation
- Instruction format:
  - [15:12] OP
  - [11:9] RD
  - [8:6] RA
  - [5:3] RB
  - [2:0] ignored
- ALU opcodes, issued as-is with S_ALU=OP, A=R[RA], B=R[RB], result written to RD, flags latched: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 1000 SLL, 1001 SLR, 1010 SRL, 1011 SRA.
- 0110 CMP: issued with S_ALU=0001. Flags latched; no register write; WB_VALID stays 0.
- 1100 LI: R[RD] <= sign-extended INSTR[8:0]. ALU not used (S_ALU stays 1111). Flags unchanged.
- 1111 NOP: no write, flags unchanged.
- 0101, 0111, 1101, 1110 are illegal: ERR pulses in WB; no write; flags unchanged.
- Outside EXEC, S_ALU is held at 1111 (INON). The ALU's stale flags under INON are never latched.
- FSM states and transitions:
  - IDLE → EXEC on INSTR_VALID && INSTR_READY.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- INSTR_READY = (state==IDLE) && !RST.
- Register-file contents:
  - All 8 registers are general purpose (R0 is not hardwired).
  - Reset value of every register is 0.

## Timing
- Cycle t, handshake: INSTR_IN is latched. At the t edge, S_ALU, DATA_A and DATA_B are loaded from R[RA] and R[RB].
- Cycle t+1, EXEC: ALU inputs are stable. At the end of t+1, ALU_OUT and FLAG_IN are captured into internal result and flag holding registers.
- Cycle t+2, WB:
  - WB_VALID=1 (ALU ops except CMP, and LI) with WB_ADDR/WB_DATA valid; or ERR=1 for illegal opcodes.
  - Register write and FLAG_REG update occur at the end of t+2.
- Cycle t+3: IDLE; INSTR_READY=1. Throughput is one instruction per 3 cycles.
- RD_DATA reflects a write from cycle t+3 onward. There is no read-after-write hazard, because the next EXEC operand load happens no earlier than t+3.
- RD == RA in the same instruction is legal: the old value is used as the operand and the new value is written.
- Reset values, applied at the end of any cycle with RST=1:
  - state=IDLE
  - S_ALU=1111, DATA_A=0, DATA_B=0
  - FLAG_REG=0000
  - WB_VALID=0, WB_ADDR=0, WB_DATA=0, ERR=0
  - all registers 0
- RST during EXEC or WB aborts the instruction: no write, no flag update, no pulse.
- INSTR_VALID may drop or INSTR_IN may change while not READY; both are ignored.

## Structure
- Package alu_pkg holds:
  - opcode constants IADD, ISUB, IAND, IOR, IXOR, ISLL, ISLR, ISRL, ISRA, INON, OP_CMP=4'b0110, OP_LI=4'b1100;
  - the FSM state encoding ST_IDLE, ST_EXEC, ST_WB;
  - the flag bit indices FLG_S=3, FLG_Z=2, FLG_C=1, FLG_V=0.
- One sub-module, regfile_8x16:
  - three combinational read ports (RA, RB, debug);
  - one synchronous write port;
  - synchronous reset to zero.
- The ALU is instantiated outside this block; its ports connect directly to S_ALU/DATA_A/DATA_B/ALU_OUT/FLAG_IN.

## Test plan
- LI R1,#5 (0xC205); LI R2,#3 (0xC403); ADD R3,R1,R2 (0x0650) -> WB_VALID with WB_ADDR=3, WB_DATA=0x0008; FLAG_REG=0000; RD_DATA(3)=0x0008.
- LI R1,#-1 (0xC3FF) -> R1=0xFFFF; LI R2,#1; ADD R3,R1,R2 -> WB_DATA=0x0000, FLAG_REG=0110.
- CMP R0,R1,R1 (0x6048) with R1=0x0005 -> no WB_VALID; FLAG_REG Z=1; all registers unchanged.
- Illegal 0x7000 -> ERR high exactly at t+2, no WB_VALID, FLAG_REG unchanged. NOP 0xF000 -> nothing changes and S_ALU stays 1111 throughout.
- INSTR_VALID held high with 3 back-to-back LIs -> accepted at cycles 0, 3 and 6. INSTR_READY is low in EXEC and WB; no instruction is dropped or duplicated.
- RST pulsed during EXEC of ADD R3 -> no write to R3. After RST deasserts: all outputs at reset values, INSTR_READY=1, RD_DATA=0 for all addresses.
